// File: rtl/fp32_divider_seq.sv
// Iterative FP32 divider: restoring quotient loop, ItersPerCycle bits per clock, start/done handshake.
// Optional sticky error/overflow accumulator enabled by defining FP_DIV_STICKY_FLAGS_EN.
module fp32_divider_seq #(
    parameter int unsigned ItersPerCycle = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  round_mode_i,
`ifdef FP_DIV_STICKY_FLAGS_EN
    input  logic        clear_flags_i,
    output logic [1:0]  sticky_flags_o,
`endif
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_div_o,
    output logic        error_div_o,
    output logic        overflow_div_o
);
    localparam int unsigned NumCycles = (26 + ItersPerCycle - 1) / ItersPerCycle;

    typedef enum logic [1:0] {StIdle, StDiv, StRound, StFin} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [25:0] rem_q, rem_d, quo_q, quo_d;
    logic [23:0] mb_q, mb_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d, spec_q, spec_d, spec_err_q, spec_err_d, spec_ovf_q, spec_ovf_d;
    logic [1:0]  rm_q, rm_d;
    logic [31:0] spec_res_q, spec_res_d, res_q, res_d;
    logic        err_q, err_d, ovf_q, ovf_d;

    // Operand decode; exponent 0 is flushed to signed zero.
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in, adj;
    logic [9:0]  exp_in;
    assign ea     = a_i[30:23];
    assign eb     = b_i[30:23];
    assign ma     = {1'b1, a_i[22:0]};
    assign mb     = {1'b1, b_i[22:0]};
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    assign s_in   = a_i[31] ^ b_i[31];
    assign adj    = (ma < mb);
    assign exp_in = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, adj};

    logic        in_spec, sp_err, sp_ovf;
    logic [31:0] sp_res;
    always_comb begin
        in_spec = 1'b1;
        sp_res  = {s_in, 31'd0};
        sp_err  = 1'b0;
        sp_ovf  = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            sp_res = 32'h7FC0_0000;
            sp_err = 1'b1;
        end else if (a_inf) begin
            sp_res = {s_in, 8'hFF, 23'd0};
        end else if (b_inf) begin
            sp_res = {s_in, 31'd0};
        end else if (b_zero) begin
            sp_res = {s_in, 8'hFF, 23'd0};
            sp_err = 1'b1;
            sp_ovf = 1'b1;
        end else if (a_zero) begin
            sp_res = {s_in, 31'd0};
        end else begin
            in_spec = 1'b0;
        end
    end

    // Restoring step(s): remainder stays below 2*Mb, so 26 bits never overflow.
    logic [25:0] rem_n, quo_n;
    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        for (int i = 0; i < int'(ItersPerCycle); i++) begin
            if (rem_n >= {2'b00, mb_q}) begin
                quo_n = {quo_n[24:0], 1'b1};
                rem_n = (rem_n - {2'b00, mb_q}) << 1;
            end else begin
                quo_n = {quo_n[24:0], 1'b0};
                rem_n = rem_n << 1;
            end
        end
    end

    // quo_q = {1.int, 23 frac, G, R}
    logic        g_bit, r_bit, lsb, sticky, inexact, inc;
    logic [24:0] mant_r;
    logic [9:0]  exp_r;
    logic [31:0] rnd_res;
    logic        rnd_err, rnd_ovf;
    assign g_bit   = quo_q[1];
    assign r_bit   = quo_q[0];
    assign lsb     = quo_q[2];
    assign sticky  = |rem_q;
    assign inexact = g_bit | r_bit | sticky;
    always_comb begin
        unique case (rm_q)
            2'b00:   inc = ~sign_q & inexact;
            2'b01:   inc = sign_q & inexact;
            2'b10:   inc = g_bit & (r_bit | sticky | lsb);
            default: inc = 1'b0;
        endcase
        mant_r  = {1'b0, quo_q[25:2]} + {24'd0, inc};
        exp_r   = exp_q + {9'd0, mant_r[24]};
        rnd_err = 1'b0;
        rnd_ovf = 1'b0;
        if ($signed(exp_r) >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'd0};
            rnd_err = 1'b1;
            rnd_ovf = 1'b1;
        end else if ($signed(exp_r) <= 10'sd0) begin
            rnd_res = {sign_q, 31'd0};
        end else begin
            rnd_res = {sign_q, exp_r[7:0], mant_r[24] ? 23'd0 : mant_r[22:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        mb_d       = mb_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        rm_d       = rm_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_err_d = spec_err_q;
        spec_ovf_d = spec_ovf_q;
        res_d      = res_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rem_d      = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
                    quo_d      = 26'd0;
                    mb_d       = mb;
                    exp_d      = exp_in;
                    sign_d     = s_in;
                    rm_d       = round_mode_i;
                    spec_d     = in_spec;
                    spec_res_d = sp_res;
                    spec_err_d = sp_err;
                    spec_ovf_d = sp_ovf;
                    cnt_d      = 5'd0;
                    // Specials skip the loop but still pass through ROUND.
                    state_d    = in_spec ? StRound : StDiv;
                end
            end
            StDiv: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(NumCycles - 1)) state_d = StRound;
            end
            StRound: begin
                res_d   = spec_q ? spec_res_q : rnd_res;
                err_d   = spec_q ? spec_err_q : rnd_err;
                ovf_d   = spec_q ? spec_ovf_q : rnd_ovf;
                state_d = StFin;
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            rem_q      <= 26'd0;
            quo_q      <= 26'd0;
            mb_q       <= 24'd0;
            exp_q      <= 10'd0;
            sign_q     <= 1'b0;
            rm_q       <= 2'b00;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            spec_err_q <= 1'b0;
            spec_ovf_q <= 1'b0;
            res_q      <= 32'd0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            mb_q       <= mb_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            rm_q       <= rm_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_err_q <= spec_err_d;
            spec_ovf_q <= spec_ovf_d;
            res_q      <= res_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy_o         = (state_q == StDiv) || (state_q == StRound);
    assign done_o         = (state_q == StFin);
    assign result_div_o   = res_q;
    assign error_div_o    = err_q;
    assign overflow_div_o = ovf_q;

`ifdef FP_DIV_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;
    always_comb begin
        sticky_d = clear_flags_i ? 2'b00 : sticky_q;
        if (done_o) sticky_d = sticky_d | {err_q, ovf_q};
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sticky_q <= 2'b00;
        else         sticky_q <= sticky_d;
    end
    assign sticky_flags_o = sticky_q;
`endif
endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed-vector bench for fp32_divider_seq (ItersPerCycle = 1).
module tb_fp32_divider_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  rm = 2'b10;
    logic        busy, done, err, ovf;
    logic [31:0] res;
`ifdef FP_DIV_STICKY_FLAGS_EN
    logic        clear_flags = 1'b0;
    logic [1:0]  sticky_flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp32_divider_seq #(.ItersPerCycle(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .a_i            (a),
        .b_i            (b),
        .round_mode_i   (rm),
`ifdef FP_DIV_STICKY_FLAGS_EN
        .clear_flags_i  (clear_flags),
        .sticky_flags_o (sticky_flags),
`endif
        .busy_o         (busy),
        .done_o         (done),
        .result_div_o   (res),
        .error_div_o    (err),
        .overflow_div_o (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Asserts start in the cycle after the previous done; lat counts cycles with start's as 0.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] irm,
                          output logic [31:0] ores, output logic oerr, output logic oovf,
                          output int lat);
        @(posedge clk); #1;
        a = ia; b = ib; rm = irm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ores = res; oerr = err; oovf = ovf;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic        err;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic [31:0] r;
        logic        e, o;
        int          lat, ndone;
        logic [31:0] first_res;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 2'b10, 32'h40400000, 1'b0, 1'b0, 28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 1'b0, 1'b0, 28};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 1'b0, 1'b0, 28};
        vecs[5]  = '{32'hBF800000, 32'h40400000, 2'b01, 32'hBEAAAAAB, 1'b0, 1'b0, 28};
        vecs[6]  = '{32'h3F800000, 32'h00000000, 2'b10, 32'h7F800000, 1'b1, 1'b1, 2};
        vecs[7]  = '{32'h00000000, 32'h00000000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 2};
        vecs[8]  = '{32'h7F000000, 32'h3E800000, 2'b10, 32'h7F800000, 1'b1, 1'b1, 28};
        vecs[9]  = '{32'h00800000, 32'h40000000, 2'b10, 32'h00000000, 1'b0, 1'b0, 28};
        vecs[10] = '{32'h7F800000, 32'h40000000, 2'b10, 32'h7F800000, 1'b0, 1'b0, 2};
        vecs[11] = '{32'h40000000, 32'hFF800000, 2'b10, 32'h80000000, 1'b0, 1'b0, 2};
        vecs[12] = '{32'h7FC00001, 32'h3F800000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 2};
        vecs[13] = '{32'h7F800000, 32'hFF800000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 2};
        vecs[14] = '{32'h00400000, 32'h3F800000, 2'b10, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[15] = '{32'h3F800000, 32'h3F7FFFFF, 2'b10, 32'h3F800001, 1'b0, 1'b0, 28};
        vecs[16] = '{32'h3F800000, 32'h3F7FFFFF, 2'b11, 32'h3F800000, 1'b0, 1'b0, 28};
        vecs[17] = '{32'h7F000000, 32'h3F800000, 2'b10, 32'h7F000000, 1'b0, 1'b0, 28};
        vecs[18] = '{32'h01000000, 32'h40000000, 2'b10, 32'h00800000, 1'b0, 1'b0, 28};

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, r, e, o, lat);
            check($sformatf("v%0d_res", i), r, vecs[i].res);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_hold", i), res, vecs[i].res);
        end

        // Repeated start while busy must be ignored.
        @(posedge clk); #1;
        a = 32'h40C00000; b = 32'h40000000; rm = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'h3F800000; b = 32'h00000000;
        ndone = 0;
        first_res = 32'd0;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                ndone++;
                first_res = res;
            end
            start = (c >= 4 && c <= 19);
            @(posedge clk); #1;
        end
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_res", first_res, 32'h40400000);

        // Reset in the middle of the loop.
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40400000; rm = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_res", res, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 2'b10, r, e, o, lat);
        check("post_rst_res", r, 32'h40400000);
        check("post_rst_lat", 32'(lat), 32'd28);

        // Back-to-back: special immediately after a normal op.
        run_op(32'h3F800000, 32'h00000000, 2'b10, r, e, o, lat);
        check("b2b_res", r, 32'h7F800000);
        check("b2b_err", {31'd0, e}, 32'd1);
        check("b2b_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
